i2c_receiver_fsm: RTL and testbench

I2C target-side write receiver; the far end of the bus driven by the transmitter sequencer.
- Oversamples the open-drain SCL/SDA lines on the system clock and detects START, repeated START and STOP.
- Shifts in a 7-bit address plus R/W bit, then ACKs and delivers each write data byte on a valid/ready handshake.
- Sits between the pad I/O (SDA pull-down enable) and the downstream register/FIFO consumer.

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_line_sync.sv | 45 ++++
 rtl/i2c_receiver_fsm.sv | 206 ++++++++++++++++++++
 tb/tb_i2c_receiver_fsm.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target write receiver: one-hot FSM states,
// the general call address and the byte bit count.
package i2c_pkg;

    typedef enum logic [5:0] {
        ST_IDLE     = 6'b000001,
        ST_ADDR     = 6'b000010,
        ST_ADDR_ACK = 6'b000100,
        ST_DATA     = 6'b001000,
        ST_DATA_ACK = 6'b010000,
        ST_IGNORE   = 6'b100000
    } rx_state_e;

    localparam logic [6:0] I2C_GENERAL_CALL_ADDR = 7'h00;
    localparam logic [3:0] BYTE_BITS             = 4'd8;
    localparam logic [3:0] LAST_BIT              = BYTE_BITS - 4'd1;

    function automatic logic byte_done(input logic [3:0] cnt);
        return cnt == BYTE_BITS;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer plus one-sample history; derives single-clock SCL edge
// and START/STOP pulses. Flops reset to 1 so the bus looks idle out of reset.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_o,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_evt_o,
    output logic stop_evt_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
            sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_o      = scl_sync_q[SYNC_STAGES-1];
    assign sda_o      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise_o = scl_o & ~scl_prev_q;
    assign scl_fall_o = ~scl_o & scl_prev_q;
    // SCL must be high in both samples, so a simultaneous SCL/SDA change is no event
    assign start_evt_o = scl_o & scl_prev_q & sda_prev_q & ~sda_o;
    assign stop_evt_o  = scl_o & scl_prev_q & ~sda_prev_q & sda_o;

endmodule

// File: rtl/i2c_receiver_fsm.sv
// I2C target-side write receiver: address match, ACK generation and byte delivery
// on a valid/ready handshake. Define I2C_RX_GENERAL_CALL_EN to also accept 7'h00/W.
module i2c_receiver_fsm
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       addr_match,
    output logic       busy,
    output logic       stop_seen,
    output logic       overrun
`ifdef I2C_RX_GENERAL_CALL_EN
    ,
    output logic       gen_call
`endif
);

    logic scl_lvl, sda_lvl, scl_rise, scl_fall, start_evt, stop_evt;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clock       (clock),
        .reset_n     (reset_n),
        .scl_i       (scl_in),
        .sda_i       (sda_in),
        .scl_o       (scl_lvl),
        .sda_o       (sda_lvl),
        .scl_rise_o  (scl_rise),
        .scl_fall_o  (scl_fall),
        .start_evt_o (start_evt),
        .stop_evt_o  (stop_evt)
    );

    logic unused_scl_lvl;
    assign unused_scl_lvl = scl_lvl;

    rx_state_e  state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       addr_match_q, addr_match_d;
    logic       busy_q, busy_d;
    logic       stop_seen_q, stop_seen_d;
    logic       overrun_q, overrun_d;
    logic       addr_ok_q, addr_ok_d;
    logic       ready_q, ready_d;
`ifdef I2C_RX_GENERAL_CALL_EN
    logic       gc_hit_q, gc_hit_d;
    logic       gen_call_q, gen_call_d;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'h00;
            rx_data_q    <= 8'h00;
            sda_oe_q     <= 1'b0;
            rx_valid_q   <= 1'b0;
            addr_match_q <= 1'b0;
            busy_q       <= 1'b0;
            stop_seen_q  <= 1'b0;
            overrun_q    <= 1'b0;
            addr_ok_q    <= 1'b0;
            ready_q      <= 1'b0;
`ifdef I2C_RX_GENERAL_CALL_EN
            gc_hit_q     <= 1'b0;
            gen_call_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            sda_oe_q     <= sda_oe_d;
            rx_valid_q   <= rx_valid_d;
            addr_match_q <= addr_match_d;
            busy_q       <= busy_d;
            stop_seen_q  <= stop_seen_d;
            overrun_q    <= overrun_d;
            addr_ok_q    <= addr_ok_d;
            ready_q      <= ready_d;
`ifdef I2C_RX_GENERAL_CALL_EN
            gc_hit_q     <= gc_hit_d;
            gen_call_q   <= gen_call_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        if (start_evt) begin
            state_d = ST_ADDR;
        end else if (stop_evt) begin
            state_d = ST_IDLE;
        end else if (scl_fall) begin
            case (state_q)
                ST_ADDR:     if (byte_done(bit_cnt_q)) state_d = addr_ok_q ? ST_ADDR_ACK : ST_IGNORE;
                ST_ADDR_ACK: state_d = ST_DATA;
                ST_DATA:     if (byte_done(bit_cnt_q)) state_d = ST_DATA_ACK;
                ST_DATA_ACK: state_d = ready_q ? ST_DATA : ST_IGNORE;
                default:     state_d = state_q;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        sda_oe_d     = sda_oe_q;
        rx_valid_d   = 1'b0;
        addr_match_d = addr_match_q;
        busy_d       = busy_q;
        stop_seen_d  = 1'b0;
        overrun_d    = 1'b0;
        addr_ok_d    = addr_ok_q;
        ready_d      = rx_valid_q ? rx_ready : ready_q;
`ifdef I2C_RX_GENERAL_CALL_EN
        gc_hit_d     = gc_hit_q;
        gen_call_d   = gen_call_q;
`endif
        if (start_evt) begin
            bit_cnt_d    = 4'd0;
            shift_d      = 8'h00;
            busy_d       = 1'b1;
            sda_oe_d     = 1'b0;
            addr_match_d = 1'b0;
`ifdef I2C_RX_GENERAL_CALL_EN
            gen_call_d   = 1'b0;
`endif
        end else if (stop_evt) begin
            sda_oe_d     = 1'b0;
            busy_d       = 1'b0;
            addr_match_d = 1'b0;
            stop_seen_d  = 1'b1;
`ifdef I2C_RX_GENERAL_CALL_EN
            gen_call_d   = 1'b0;
`endif
        end else begin
            // Counter saturation stops ACK-slot rises from shifting data
            if (scl_rise && (state_q == ST_ADDR || state_q == ST_DATA) && !byte_done(bit_cnt_q)) begin
                shift_d   = {shift_q[6:0], sda_lvl};
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == LAST_BIT) begin
                    if (state_q == ST_ADDR) begin
                        addr_ok_d = (shift_d[7:1] == ADDR) && !shift_d[0];
`ifdef I2C_RX_GENERAL_CALL_EN
                        gc_hit_d  = (shift_d[7:1] == I2C_GENERAL_CALL_ADDR) && !shift_d[0];
                        addr_ok_d = addr_ok_d || gc_hit_d;
`endif
                    end else begin
                        rx_data_d  = shift_d;
                        rx_valid_d = 1'b1;
                    end
                end
            end
            if (scl_fall) begin
                case (state_q)
                    ST_ADDR: if (byte_done(bit_cnt_q)) sda_oe_d = addr_ok_q;
                    ST_ADDR_ACK: begin
                        sda_oe_d     = 1'b0;
                        addr_match_d = 1'b1;
                        bit_cnt_d    = 4'd0;
`ifdef I2C_RX_GENERAL_CALL_EN
                        gen_call_d   = gc_hit_q;
`endif
                    end
                    ST_DATA: begin
                        if (byte_done(bit_cnt_q)) begin
                            sda_oe_d  = ready_q;
                            overrun_d = ~ready_q;
                        end
                    end
                    ST_DATA_ACK: begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                    end
                    default: sda_oe_d = 1'b0;
                endcase
            end
        end
    end

    assign sda_oe     = sda_oe_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign addr_match = addr_match_q;
    assign busy       = busy_q;
    assign stop_seen  = stop_seen_q;
    assign overrun    = overrun_q;
`ifdef I2C_RX_GENERAL_CALL_EN
    assign gen_call   = gen_call_q;
`endif

endmodule

// File: tb/tb_i2c_receiver_fsm.sv
// Directed bench for i2c_receiver_fsm: a bench-driven I2C controller with a
// wired-AND SDA line; each scenario task checks its own expected values.
module tb_i2c_receiver_fsm;

    logic       clock    = 1'b0;
    logic       reset_n  = 1'b0;
    logic       scl_m    = 1'b1;
    logic       sda_m    = 1'b1;
    logic       rx_ready = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid, addr_match, busy, stop_seen, overrun;
`ifdef I2C_RX_GENERAL_CALL_EN
    logic       gen_call;
`endif

    int errors = 0;
    int checks = 0;

    int valid_cnt = 0, stop_cnt = 0, ovr_cnt = 0, oe_cnt = 0, viol_cnt = 0;
    logic prev_scl = 1'b1, prev_oe = 1'b0;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clock = ~clock;

    i2c_receiver_fsm #(.ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .scl_in     (scl_m),
        .sda_in     (sda_line),
        .sda_oe     (sda_oe),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .addr_match (addr_match),
        .busy       (busy),
        .stop_seen  (stop_seen),
        .overrun    (overrun)
`ifdef I2C_RX_GENERAL_CALL_EN
        ,
        .gen_call   (gen_call)
`endif
    );

    // Event monitors; scenarios compare deltas of these counts
    always @(negedge clock) begin
        if (rx_valid)  valid_cnt++;
        if (stop_seen) stop_cnt++;
        if (overrun)   ovr_cnt++;
        if (sda_oe)    oe_cnt++;
        if (reset_n && scl_m && prev_scl && sda_oe !== prev_oe) viol_cnt++;
        prev_scl = scl_m;
        prev_oe  = sda_oe;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b, output logic oe_high);
        wait_clk(4);
        sda_m = b;
        wait_clk(4);
        scl_m = 1'b1;
        wait_clk(3);
        @(negedge clock);
        oe_high = sda_oe;
        wait_clk(1);
        scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) send_bit(b[i], dummy);
        send_bit(1'b1, ack);
    endtask

    task automatic do_start();
        wait_clk(4);
        sda_m = 1'b1;
        wait_clk(4);
        scl_m = 1'b1;
        wait_clk(4);
        sda_m = 1'b0;
        wait_clk(4);
        scl_m = 1'b0;
    endtask

    task automatic do_stop();
        wait_clk(4);
        sda_m = 1'b0;
        wait_clk(4);
        scl_m = 1'b1;
        wait_clk(4);
        sda_m = 1'b1;
        wait_clk(8);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wait_clk(2);
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe_in_reset: got %b expected 0", sda_oe); end
        reset_n = 1'b1;
        wait_clk(3);
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL reset_addr_match: got %b expected 0", addr_match); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (stop_seen !== 1'b0) begin errors++; $display("FAIL reset_stop_seen: got %b expected 0", stop_seen); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_basic_write();
        logic ack;
        int v0, s0;
        v0 = valid_cnt; s0 = stop_cnt;
        do_start();
        wait_clk(4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start: got %b expected 1", busy); end
        send_byte(8'h84, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL basic_addr_ack: got %b expected 1", ack); end
        wait_clk(5);
        checks++; if (addr_match !== 1'b1) begin errors++; $display("FAIL basic_addr_match: got %b expected 1", addr_match); end
        send_byte(8'hA5, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL basic_data_ack: got %b expected 1", ack); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL basic_rx_data: got %h expected a5", rx_data); end
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL basic_valid_count: got %0d expected 1", valid_cnt - v0); end
        do_stop();
        checks++; if (stop_cnt - s0 !== 1) begin errors++; $display("FAIL basic_stop_count: got %0d expected 1", stop_cnt - s0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after_stop: got %b expected 0", busy); end
        checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL basic_addr_match_after_stop: got %b expected 0", addr_match); end
        $display("test_basic_write done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_addr_mismatch();
        logic ack;
        int v0, o0;
        v0 = valid_cnt; o0 = oe_cnt;
        do_start();
        send_byte(8'h86, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mismatch_addr_ack: got %b expected 0", ack); end
        send_byte(8'h55, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mismatch_data_ack: got %b expected 0", ack); end
        checks++; if (addr_match !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL mismatch_flags: got match=%b busy=%b expected match=0 busy=1", addr_match, busy); end
        do_stop();
        checks++; if (oe_cnt - o0 !== 0 || valid_cnt - v0 !== 0) begin errors++; $display("FAIL mismatch_activity: got oe_cycles=%0d valids=%0d expected 0 0", oe_cnt - o0, valid_cnt - v0); end
        $display("test_addr_mismatch done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_read_nack();
        logic ack;
        int o0;
        o0 = oe_cnt;
        do_start();
        send_byte(8'h85, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL read_addr_ack: got %b expected 0", ack); end
        send_byte(8'hFF, ack);
        do_stop();
        checks++; if (oe_cnt - o0 !== 0) begin errors++; $display("FAIL read_oe_activity: got %0d expected 0", oe_cnt - o0); end
        $display("test_read_nack done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_overrun();
        logic ack;
        int v0, r0;
        v0 = valid_cnt; r0 = ovr_cnt;
        rx_ready = 1'b1;
        do_start();
        send_byte(8'h84, ack);
        send_byte(8'h11, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL overrun_first_ack: got %b expected 1", ack); end
        checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL overrun_first_data: got %h expected 11", rx_data); end
        rx_ready = 1'b0;
        send_byte(8'h22, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL overrun_second_ack: got %b expected 0", ack); end
        checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL overrun_second_data: got %h expected 22", rx_data); end
        checks++; if (ovr_cnt - r0 !== 1) begin errors++; $display("FAIL overrun_pulse_count: got %0d expected 1", ovr_cnt - r0); end
        rx_ready = 1'b1;
        send_byte(8'h33, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL overrun_ignored_ack: got %b expected 0", ack); end
        checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL overrun_valid_count: got %0d expected 2", valid_cnt - v0); end
        do_stop();
        $display("test_overrun done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_repeated_start();
        logic ack, dummy;
        int v0;
        v0 = valid_cnt;
        do_start();
        send_byte(8'h84, ack);
        send_bit(1'b1, dummy);
        send_bit(1'b0, dummy);
        send_bit(1'b1, dummy);
        send_bit(1'b1, dummy);
        do_start();
        wait_clk(4);
        checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL rstart_addr_match_cleared: got %b expected 0", addr_match); end
        send_byte(8'h84, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rstart_addr_ack: got %b expected 1", ack); end
        send_byte(8'h5A, ack);
        checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL rstart_rx_data: got %h expected 5a", rx_data); end
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL rstart_valid_count: got %0d expected 1", valid_cnt - v0); end
        do_stop();
        $display("test_repeated_start done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_async_reset();
        logic dummy;
        logic [7:0] a;
        a = 8'h84;
        do_start();
        for (int i = 7; i >= 0; i--) send_bit(a[i], dummy);
        wait_clk(4);
        sda_m = 1'b1;
        wait_clk(4);
        scl_m = 1'b1;
        for (int i = 0; i < 20 && sda_oe !== 1'b1; i++) @(negedge clock);
        checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL areset_ack_driven: got %b expected 1", sda_oe); end
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL areset_sda_oe_immediate: got %b expected 0", sda_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy_immediate: got %b expected 0", busy); end
        sda_m = 1'b1;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(3);
        checks++; if (rx_data !== 8'h00 || addr_match !== 1'b0) begin errors++; $display("FAIL areset_state: got data=%h match=%b expected 00 0", rx_data, addr_match); end
        $display("test_async_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_general_call();
        logic ack;
        int v0;
        v0 = valid_cnt;
        do_start();
        send_byte(8'h00, ack);
`ifdef I2C_RX_GENERAL_CALL_EN
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL gc_addr_ack: got %b expected 1", ack); end
        wait_clk(5);
        checks++; if (gen_call !== 1'b1 || addr_match !== 1'b1) begin errors++; $display("FAIL gc_flags: got gen_call=%b match=%b expected 1 1", gen_call, addr_match); end
        send_byte(8'h3C, ack);
        checks++; if (rx_data !== 8'h3C || valid_cnt - v0 !== 1) begin errors++; $display("FAIL gc_data: got %h valids=%0d expected 3c 1", rx_data, valid_cnt - v0); end
        do_stop();
        checks++; if (gen_call !== 1'b0) begin errors++; $display("FAIL gc_after_stop: got %b expected 0", gen_call); end
`else
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL gc_addr_nack: got %b expected 0", ack); end
        send_byte(8'h3C, ack);
        checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL gc_no_data: got %0d expected 0", valid_cnt - v0); end
        do_stop();
`endif
        $display("test_general_call done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_oe_timing();
        checks++; if (viol_cnt !== 0) begin errors++; $display("FAIL oe_change_while_scl_high: got %0d expected 0", viol_cnt); end
        $display("test_oe_timing done: checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_addr_mismatch();
        test_read_nack();
        test_overrun();
        test_repeated_start();
        test_general_call();
        test_oe_timing();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
